// File: rtl/pe8_sched_pkg.sv
// pe8_sched_pkg: shared types and constants for the PE8 job sequencer.
// No ports; exports state_t, mode codes, EN_FULL, slot/result counts.
package pe8_sched_pkg;

   localparam int DEF_N   = 32;
   localparam int DEF_Q   = 19;
   localparam int DEF_LAT = 4;

   localparam int E8     = 10;
   localparam int NSLOT  = 14;
   localparam int NRES   = 7;
   localparam int NSPLIT = 9;

   // FULL jobs drive only slots 0..7; 8..13 are forced to zero.
   localparam int NFULL  = 8;

   localparam logic MODE_SPLIT = 1'b0;
   localparam logic MODE_FULL  = 1'b1;

   localparam logic [E8-1:0] EN_FULL = 10'b1000000000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } state_t;

   // Width of a down-counter that must hold lat-1.
   function automatic int cnt_width(input int lat);
      return (lat > 1) ? $clog2(lat) : 1;
   endfunction

endpackage

// File: rtl/pe8_operand_bank.sv
// pe8_operand_bank: 14-entry (in, w) register file, async clear, one write port.
// Ports: clk, rst, wr_en/wr_idx/wr_in/wr_w write port; rd_in/rd_w flat read-all.
module pe8_operand_bank
   import pe8_sched_pkg::*;
#(
   parameter int N = DEF_N
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wr_en,
   input  logic [3:0]         wr_idx,
   input  logic [N-1:0]       wr_in,
   input  logic [N-1:0]       wr_w,
   output logic [NSLOT*N-1:0] rd_in,
   output logic [NSLOT*N-1:0] rd_w
);

   logic [N-1:0] in_q [NSLOT];
   logic [N-1:0] w_q  [NSLOT];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < NSLOT; k++) begin
            in_q[k] <= '0;
            w_q[k]  <= '0;
         end
      end else if (wr_en) begin
         for (int k = 0; k < NSLOT; k++) begin
            if (wr_idx == 4'(k)) begin
               in_q[k] <= wr_in;
               w_q[k]  <= wr_w;
            end
         end
      end
   end

   always_comb begin
      rd_in = '0;
      rd_w  = '0;
      for (int k = 0; k < NSLOT; k++) begin
         rd_in[k*N +: N] = in_q[k];
         rd_w[k*N +: N]  = w_q[k];
      end
   end

endmodule

// File: rtl/pe8_sched.sv
// pe8_sched: loads operands, issues FULL/SPLIT jobs to one PE8, returns results.
// Ports: ld_* load port, cmd_* job port, pe_* engine buses, res_* result port, cfg_err.
module pe8_sched
   import pe8_sched_pkg::*;
#(
   parameter int N   = DEF_N,
   parameter int LAT = DEF_LAT
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               ld_valid,
   output logic               ld_ready,
   input  logic [3:0]         ld_idx,
   input  logic [N-1:0]       ld_in,
   input  logic [N-1:0]       ld_w,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic               cmd_mode,
   input  logic [NSPLIT-1:0]  cmd_en,
   output logic [NSLOT*N-1:0] pe_in,
   output logic [NSLOT*N-1:0] pe_w,
   output logic [E8-1:0]      pe_en,
   input  logic [NRES*N-1:0]  pe_res,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [NRES*N-1:0]  res_data,
   output logic               res_err,
   output logic               cfg_err
);

   localparam int CW = cnt_width(LAT);

   state_t state_q;
   state_t state_d;

   logic [CW-1:0]      cnt_q;
   logic               ld_fire;
   logic               cmd_fire;
   logic               res_fire;
   logic               wr_en;
   logic               rej;
   logic               cnt_zero;
   logic [NSLOT*N-1:0] bank_in;
   logic [NSLOT*N-1:0] bank_w;
   logic [NSLOT*N-1:0] job_in;
   logic [NSLOT*N-1:0] job_w;
   logic [E8-1:0]      job_en;

   assign ld_fire  = ld_valid & ld_ready;
   assign cmd_fire = cmd_valid & cmd_ready;
   assign res_fire = res_valid & res_ready;
   assign wr_en    = ld_fire && (ld_idx < 4'(NSLOT));
   assign rej      = (cmd_mode == MODE_SPLIT) && (cmd_en == '0);
   assign cnt_zero = (cnt_q == '0);

   pe8_operand_bank #(
      .N (N)
   ) u_bank (
      .clk    (clk),
      .rst    (rst),
      .wr_en  (wr_en),
      .wr_idx (ld_idx),
      .wr_in  (ld_in),
      .wr_w   (ld_w),
      .rd_in  (bank_in),
      .rd_w   (bank_w)
   );

   // A load in the accept cycle lands in the bank on the same edge,
   // so the job buses take the incoming word directly.
   always_comb begin
      job_in = bank_in;
      job_w  = bank_w;
      for (int k = 0; k < NSLOT; k++) begin
         if (wr_en && (ld_idx == 4'(k))) begin
            job_in[k*N +: N] = ld_in;
            job_w[k*N +: N]  = ld_w;
         end
         if ((cmd_mode == MODE_FULL) && (k >= NFULL)) begin
            job_in[k*N +: N] = '0;
            job_w[k*N +: N]  = '0;
         end
      end
   end

   always_comb begin
      job_en = {1'b0, cmd_en};
      if (cmd_mode == MODE_FULL) begin
         job_en = EN_FULL;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (cmd_fire) begin
               state_d = rej ? HOLD : RUN;
            end
         end
         RUN: begin
            if (cnt_zero) begin
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (res_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ld_ready  = 1'b0;
      cmd_ready = 1'b0;
      unique case (1'b1)
         (state_q == IDLE): begin
            ld_ready  = 1'b1;
            cmd_ready = 1'b1;
         end
         default: begin
            ld_ready  = 1'b0;
            cmd_ready = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q     <= '0;
         pe_in     <= '0;
         pe_w      <= '0;
         pe_en     <= '0;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_err   <= 1'b0;
         cfg_err   <= 1'b0;
      end else begin
         if (ld_fire && !wr_en) begin
            cfg_err <= 1'b1;
         end
         unique case (state_q)
            IDLE: begin
               if (cmd_fire && rej) begin
                  // Rejected job: no engine run, empty error result.
                  res_valid <= 1'b1;
                  res_err   <= 1'b1;
                  res_data  <= '0;
               end else if (cmd_fire) begin
                  pe_in <= job_in;
                  pe_w  <= job_w;
                  pe_en <= job_en;
                  cnt_q <= CW'(LAT - 1);
               end
            end
            RUN: begin
               if (cnt_zero) begin
                  res_data  <= pe_res;
                  res_valid <= 1'b1;
                  res_err   <= 1'b0;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            HOLD: begin
               if (res_fire) begin
                  res_valid <= 1'b0;
                  pe_en     <= '0;
               end
            end
            default: begin
               res_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pe8_sched.sv
// tb_pe8_sched: scoreboard bench for pe8_sched with a stand-in PE8 engine.
// Ports: none; drives every pe8_sched port and prints one summary line.
module tb_pe8_sched;
   import pe8_sched_pkg::*;

   localparam int N   = 32;
   localparam int LAT = 4;
   localparam int W   = NSLOT * N;
   localparam int RW  = NRES * N;

   typedef struct {
      logic [RW-1:0] data;
      logic          err;
   } exp_t;

   logic              clk;
   logic              rst;
   logic              ld_valid;
   logic              ld_ready;
   logic [3:0]        ld_idx;
   logic [N-1:0]      ld_in;
   logic [N-1:0]      ld_w;
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_mode;
   logic [NSPLIT-1:0] cmd_en;
   logic [W-1:0]      pe_in;
   logic [W-1:0]      pe_w;
   logic [E8-1:0]     pe_en;
   logic [RW-1:0]     pe_res;
   logic              res_valid;
   logic              res_ready;
   logic [RW-1:0]     res_data;
   logic              res_err;
   logic              cfg_err;

   int   errors;
   int   checks;
   exp_t sb[$];
   exp_t got;
   bit   rr_rand;
   bit   rr_force;

   logic [N-1:0]  m_in [NSLOT];
   logic [N-1:0]  m_w  [NSLOT];
   logic          m_cfg;
   logic [RW-1:0] eng_pipe [LAT];

   pe8_sched #(
      .N   (N),
      .LAT (LAT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .ld_valid  (ld_valid),
      .ld_ready  (ld_ready),
      .ld_idx    (ld_idx),
      .ld_in     (ld_in),
      .ld_w      (ld_w),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_mode  (cmd_mode),
      .cmd_en    (cmd_en),
      .pe_in     (pe_in),
      .pe_w      (pe_w),
      .pe_en     (pe_en),
      .pe_res    (pe_res),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_err   (res_err),
      .cfg_err   (cfg_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stand-in engine: a hash of all buses, visible LAT negedges later.
   function automatic logic [RW-1:0] engine(input logic [W-1:0] bi,
                                            input logic [W-1:0] bw,
                                            input logic [E8-1:0] en);
      logic [RW-1:0] r;
      logic [31:0]   h;
      r = '0;
      for (int j = 0; j < NRES; j++) begin
         h = 32'h9E37_79B9 + 32'(en) * 32'(j + 1);
         for (int k = 0; k < NSLOT; k++) begin
            h = (h * 32'd33) ^ (bi[k*N +: N] + bw[k*N +: N] * 32'(j + 3));
         end
         r[j*N +: N] = h;
      end
      return r;
   endfunction

   initial begin
      for (int i = 0; i < LAT; i++) eng_pipe[i] = '0;
      forever begin
         @(negedge clk);
         for (int i = LAT - 1; i > 0; i--) eng_pipe[i] = eng_pipe[i-1];
         eng_pipe[0] = engine(pe_in, pe_w, pe_en);
      end
   end
   assign pe_res = eng_pipe[LAT-1];

   initial begin
      res_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         res_ready = rr_rand ? 1'($urandom % 2) : rr_force;
      end
   end

   task automatic chkw(input string nm, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0b expected %0b", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (res_valid && res_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got res_valid=1 expected none");
         end else begin
            got = sb.pop_front();
            chkw("res_data", W'(res_data), W'(got.data));
            chk1("res_err", res_err, got.err);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (!(cmd_ready && ld_ready) && n < 60) begin
         tick();
         n++;
      end
      if (n >= 60) begin
         checks++;
         errors++;
         $display("FAIL idle_timeout: got busy expected idle within 60");
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 100) begin
         tick();
         n++;
      end
      if (n >= 100) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < NSLOT; k++) begin
         m_in[k] = '0;
         m_w[k]  = '0;
      end
      m_cfg = 1'b0;
      sb.delete();
   endtask

   task automatic model_load(input logic [3:0] idx, input logic [N-1:0] vi,
                             input logic [N-1:0] vw);
      if (int'(idx) < NSLOT) begin
         m_in[idx] = vi;
         m_w[idx]  = vw;
      end else begin
         m_cfg = 1'b1;
      end
   endtask

   function automatic logic [W-1:0] exp_bus(input logic full, input bit use_w);
      logic [W-1:0] b;
      logic [N-1:0] v;
      b = '0;
      for (int k = 0; k < NSLOT; k++) begin
         v = use_w ? m_w[k] : m_in[k];
         if (full && k >= 8) v = '0;
         b[k*N +: N] = v;
      end
      return b;
   endfunction

   task automatic load(input logic [3:0] idx, input logic [N-1:0] vi,
                       input logic [N-1:0] vw);
      wait_idle();
      ld_valid = 1'b1;
      ld_idx   = idx;
      ld_in    = vi;
      ld_w     = vw;
      tick();
      ld_valid = 1'b0;
      model_load(idx, vi, vw);
      chk1("cfg_err", cfg_err, m_cfg);
   endtask

   task automatic issue(input logic mode, input logic [NSPLIT-1:0] en,
                        input bit with_ld, input logic [3:0] idx,
                        input logic [N-1:0] vi, input logic [N-1:0] vw);
      exp_t          e;
      logic [W-1:0]  ei;
      logic [W-1:0]  ew;
      logic [E8-1:0] een;
      wait_idle();
      cmd_valid = 1'b1;
      cmd_mode  = mode;
      cmd_en    = en;
      if (with_ld) begin
         ld_valid = 1'b1;
         ld_idx   = idx;
         ld_in    = vi;
         ld_w     = vw;
      end
      tick();
      cmd_valid = 1'b0;
      ld_valid  = 1'b0;
      if (with_ld) model_load(idx, vi, vw);
      if (mode == MODE_SPLIT && en == '0) begin
         e.data = '0;
         e.err  = 1'b1;
         sb.push_back(e);
         chk1("rej_valid", res_valid, 1'b1);
         chk1("rej_err", res_err, 1'b1);
         chkw("rej_pe_en", W'(pe_en), '0);
      end else begin
         ei     = exp_bus(mode, 1'b0);
         ew     = exp_bus(mode, 1'b1);
         een    = (mode == MODE_FULL) ? 10'b1000000000 : {1'b0, en};
         e.data = engine(ei, ew, een);
         e.err  = 1'b0;
         sb.push_back(e);
         chkw("pe_en", W'(pe_en), W'(een));
         chkw("pe_in", pe_in, ei);
         chkw("pe_w", pe_w, ew);
         chk1("run_valid_low", res_valid, 1'b0);
      end
      if (with_ld) chk1("ld_cmd_cfg", cfg_err, m_cfg);
   endtask

   task automatic check_reset(input string nm);
      chk1({nm, "_ld_ready"}, ld_ready, 1'b1);
      chk1({nm, "_cmd_ready"}, cmd_ready, 1'b1);
      chkw({nm, "_pe_en"}, W'(pe_en), '0);
      chkw({nm, "_pe_in"}, pe_in, '0);
      chkw({nm, "_pe_w"}, pe_w, '0);
      chk1({nm, "_res_valid"}, res_valid, 1'b0);
      chkw({nm, "_res_data"}, W'(res_data), '0);
      chk1({nm, "_res_err"}, res_err, 1'b0);
      chk1({nm, "_cfg_err"}, cfg_err, 1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish expected finish by 2ms");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [RW-1:0] held;
      int            n;
      errors    = 0;
      checks    = 0;
      rr_rand   = 1'b0;
      rr_force  = 1'b1;
      rst       = 1'b1;
      ld_valid  = 1'b0;
      ld_idx    = '0;
      ld_in     = '0;
      ld_w      = '0;
      cmd_valid = 1'b0;
      cmd_mode  = 1'b0;
      cmd_en    = '0;
      model_reset();
      repeat (3) tick();
      rst = 1'b0;
      tick();
      check_reset("reset");

      // FULL job with a fixed operand pattern and junk in slots 8..13.
      for (int k = 0; k < 8; k++) load(4'(k), 32'h0019_21FB, 32'h0008_0000);
      for (int k = 8; k < NSLOT; k++) load(4'(k), $urandom, $urandom);
      issue(MODE_FULL, 9'h1FF, 1'b0, '0, '0, '0);
      repeat (LAT - 1) tick();
      chk1("full_not_early", res_valid, 1'b0);
      tick();
      chk1("full_valid_at_lat", res_valid, 1'b1);
      drain();

      // SPLIT job over all 14 slots.
      for (int k = 0; k < NSLOT; k++) load(4'(k), $urandom, $urandom);
      issue(MODE_SPLIT, 9'b000001111, 1'b0, '0, '0, '0);
      drain();

      // Back-pressure: result must stay put and commands must wait.
      rr_force = 1'b0;
      issue(MODE_SPLIT, 9'h0A5, 1'b0, '0, '0, '0);
      n = 0;
      while (!res_valid && n < 20) begin
         tick();
         n++;
      end
      chk1("bp_valid", res_valid, 1'b1);
      held = res_data;
      for (int i = 0; i < 10; i++) begin
         cmd_valid = 1'b1;
         cmd_mode  = MODE_FULL;
         tick();
         chk1("bp_hold_valid", res_valid, 1'b1);
         chkw("bp_hold_data", W'(res_data), W'(held));
         chk1("bp_cmd_ready", cmd_ready, 1'b0);
      end
      cmd_valid = 1'b0;
      rr_force  = 1'b1;
      drain();

      // Rejected SPLIT job.
      issue(MODE_SPLIT, '0, 1'b0, '0, '0, '0);
      drain();

      // Out-of-range load is dropped and flags cfg_err.
      load(4'd15, 32'hDEAD_BEEF, 32'hCAFE_F00D);
      issue(MODE_SPLIT, 9'h1FF, 1'b0, '0, '0, '0);
      drain();

      // Load and command in the same cycle.
      issue(MODE_SPLIT, 9'h1FF, 1'b1, 4'd10, $urandom, $urandom);
      issue(MODE_FULL, 9'h000, 1'b1, 4'd3, $urandom, $urandom);
      drain();

      // Reset in the middle of a job.
      issue(MODE_FULL, 9'h000, 1'b0, '0, '0, '0);
      tick();
      rst = 1'b1;
      #1;
      model_reset();
      check_reset("mid_rst");
      tick();
      rst = 1'b0;
      for (int i = 0; i < LAT + 3; i++) begin
         tick();
         chk1("no_valid_after_rst", res_valid, 1'b0);
      end

      // Random traffic with random back-pressure.
      rr_rand = 1'b1;
      for (int j = 0; j < 40; j++) begin
         n = int'($urandom % 4);
         for (int i = 0; i < n; i++) load(4'($urandom % 16), $urandom, $urandom);
         issue(1'($urandom % 2),
               ($urandom % 5 == 0) ? 9'h000 : 9'($urandom),
               ($urandom % 4 == 0), 4'($urandom % 16), $urandom, $urandom);
      end
      rr_rand  = 1'b0;
      rr_force = 1'b1;
      drain();
      chk1("sb_empty", sb.size() == 0, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
